acc_drain_serializer: RTL and testbench



---
 rtl/systolic_pkg.sv | 14 +
 rtl/drain_shadow_buf.sv | 34 +++
 rtl/acc_drain_serializer.sv | 93 +++++++++
 tb/tb_acc_drain_serializer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared constants and types for the systolic array datapath
package systolic_pkg;

  localparam int ARRAY_DIM = 16;
  localparam int ACC_W     = 32;

  typedef logic signed [ACC_W-1:0] acc_word_t;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_t;

endpackage

// File: rtl/drain_shadow_buf.sv
// rtl/drain_shadow_buf.sv - parallel-load shadow register file with indexed read
module drain_shadow_buf
  import systolic_pkg::*;
#(
  parameter int N_ROWS = ARRAY_DIM,
  parameter int DATA_W = ACC_W,
  parameter int IDX_W  = $clog2(N_ROWS)
) (
  input  logic                     clk,
  input  logic                     nRST,
  input  logic                     load,
  input  logic [N_ROWS*DATA_W-1:0] load_data,
  input  logic [IDX_W-1:0]         rd_idx,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem [N_ROWS];

  // Snapshot the whole column in one edge so the accumulators can be cleared at once
  always_ff @(posedge clk) begin
    if (!nRST) begin
      for (int r = 0; r < N_ROWS; r++) begin
        mem[r] <= '0;
      end
    end else if (load) begin
      for (int r = 0; r < N_ROWS; r++) begin
        mem[r] <= load_data[r*DATA_W +: DATA_W];
      end
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/acc_drain_serializer.sv
// rtl/acc_drain_serializer.sv - column accumulator drain: snapshot, clear, stream one row per beat
module acc_drain_serializer
  import systolic_pkg::*;
#(
  parameter int N_ROWS = ARRAY_DIM,
  parameter int DATA_W = ACC_W,
  parameter int IDX_W  = $clog2(N_ROWS)
) (
  input  logic                     clk,
  input  logic                     nRST,
  input  logic                     tile_done,
  input  logic [N_ROWS*DATA_W-1:0] acc_sum,
  output logic                     acc_clear,
  output logic                     done_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [IDX_W-1:0]         out_idx,
  output logic                     out_last,
  output logic                     overrun,
  output logic [15:0]              tiles_drained
);

  drain_state_t     state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] shadow_rd;
  logic             at_last;
  logic             beat_fire;
  logic             last_fire;
  logic             accept;

  drain_shadow_buf #(
    .N_ROWS (N_ROWS),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_shadow (
    .clk       (clk),
    .nRST      (nRST),
    .load      (accept),
    .load_data (acc_sum),
    .rd_idx    (idx_q),
    .rd_data   (shadow_rd)
  );

  assign at_last   = (idx_q == IDX_W'(N_ROWS - 1));
  assign out_valid = (state_q == DRAIN);
  assign out_idx   = out_valid ? idx_q : '0;
  assign out_data  = out_valid ? shadow_rd : '0;
  assign out_last  = out_valid & at_last;

  assign beat_fire = out_valid & out_ready;
  assign last_fire = beat_fire & out_last;

  // A new tile fits either when idle or in the very cycle the final beat leaves
  assign done_ready = (state_q == IDLE) | last_fire;
  assign accept     = tile_done & done_ready;
  assign acc_clear  = accept;

  // Next state and row index; a back-to-back accept restarts at row 0 with no bubble
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (accept) begin
      state_d = DRAIN;
      idx_d   = '0;
    end else if (last_fire) begin
      state_d = IDLE;
      idx_d   = '0;
    end else if (beat_fire) begin
      idx_d   = idx_q + IDX_W'(1);
    end
  end

  // State, index, sticky overrun flag and drained-tile counter
  always_ff @(posedge clk) begin
    if (!nRST) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      overrun       <= 1'b0;
      tiles_drained <= 16'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (tile_done && !done_ready) begin
        overrun <= 1'b1;
      end
      if (last_fire) begin
        tiles_drained <= tiles_drained + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_acc_drain_serializer.sv
// tb/tb_acc_drain_serializer.sv - directed self-checking bench for acc_drain_serializer
module tb_acc_drain_serializer;

  localparam int N_ROWS = 16;
  localparam int DATA_W = 32;
  localparam int IDX_W  = 4;

  logic                     clk;
  logic                     nRST;
  logic                     tile_done;
  logic [N_ROWS*DATA_W-1:0] acc_sum;
  logic                     acc_clear;
  logic                     done_ready;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W-1:0]        out_data;
  logic [IDX_W-1:0]         out_idx;
  logic                     out_last;
  logic                     overrun;
  logic [15:0]              tiles_drained;

  int n_checks;
  int n_err;

  acc_drain_serializer #(
    .N_ROWS (N_ROWS),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) dut (
    .clk           (clk),
    .nRST          (nRST),
    .tile_done     (tile_done),
    .acc_sum       (acc_sum),
    .acc_clear     (acc_clear),
    .done_ready    (done_ready),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_idx       (out_idx),
    .out_last      (out_last),
    .overrun       (overrun),
    .tiles_drained (tiles_drained)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // kind 0: r*100-5   kind 1: 7FFFFFFF/80000000 alternating   kind 2: A0000000+3r   kind 3: 55555555
  function automatic logic [31:0] pat(input int kind, input int r);
    case (kind)
      0:       pat = 32'(r * 100 - 5);
      1:       pat = (r % 2 == 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
      2:       pat = 32'hA000_0000 + 32'(r * 3);
      default: pat = 32'h5555_5555;
    endcase
  endfunction

  task automatic load_sum(input int kind);
    for (int r = 0; r < N_ROWS; r++) begin
      acc_sum[r*DATA_W +: DATA_W] = pat(kind, r);
    end
  endtask

  // Checks beats first..last of a tile with out_ready held high, one beat per cycle
  task automatic drain_beats(input string tag, input int kind, input int first, input int last);
    for (int k = first; k <= last; k++) begin
      #1;
      check({tag, "_valid"}, 64'(out_valid), 64'(1));
      check({tag, "_idx"},   64'(out_idx),   64'(k));
      check({tag, "_data"},  64'(out_data),  64'(pat(kind, k)));
      check({tag, "_last"},  64'(out_last),  64'(k == N_ROWS - 1));
      check({tag, "_clr"},   64'(acc_clear), 64'(0));
      tick;
    end
  endtask

  initial begin
    int beat;
    int c;
    n_checks  = 0;
    n_err     = 0;
    nRST      = 1'b0;
    tile_done = 1'b0;
    out_ready = 1'b0;
    acc_sum   = '0;
    tick;
    tick;
    nRST = 1'b1;
    #1;
    check("rst_valid",   64'(out_valid),     64'(0));
    check("rst_data",    64'(out_data),      64'(0));
    check("rst_idx",     64'(out_idx),       64'(0));
    check("rst_last",    64'(out_last),      64'(0));
    check("rst_clear",   64'(acc_clear),     64'(0));
    check("rst_overrun", 64'(overrun),       64'(0));
    check("rst_tiles",   64'(tiles_drained), 64'(0));
    check("rst_ready",   64'(done_ready),    64'(1));
    out_ready = 1'b1;
    #1;
    check("idle_ignores_ready", 64'(out_valid), 64'(0));

    // Basic drain
    tick;
    load_sum(0);
    tile_done = 1'b1;
    #1;
    check("basic_clr_hi", 64'(acc_clear),  64'(1));
    check("basic_dr",     64'(done_ready), 64'(1));
    check("basic_v0",     64'(out_valid),  64'(0));
    tick;
    tile_done = 1'b0;
    acc_sum   = '0;
    drain_beats("basic", 0, 0, 15);
    #1;
    check("basic_idle",  64'(out_valid),     64'(0));
    check("basic_tiles", 64'(tiles_drained), 64'(1));
    check("basic_dr2",   64'(done_ready),    64'(1));

    // Backpressure: out_ready 1,0,0,1 repeating
    tick;
    load_sum(2);
    tile_done = 1'b1;
    #1;
    check("bp_clr", 64'(acc_clear), 64'(1));
    tick;
    tile_done = 1'b0;
    acc_sum   = '0;
    beat = 0;
    c    = 0;
    while (beat < N_ROWS && c < 200) begin
      out_ready = (c % 4 == 0) || (c % 4 == 3);
      #1;
      check("bp_valid", 64'(out_valid), 64'(1));
      check("bp_idx",   64'(out_idx),   64'(beat));
      check("bp_data",  64'(out_data),  64'(pat(2, beat)));
      check("bp_last",  64'(out_last),  64'(beat == N_ROWS - 1));
      if (out_ready) beat++;
      c++;
      tick;
    end
    check("bp_beats", 64'(beat), 64'(N_ROWS));
    #1;
    check("bp_idle",  64'(out_valid),     64'(0));
    check("bp_tiles", 64'(tiles_drained), 64'(2));

    // Back-to-back tiles
    out_ready = 1'b1;
    tick;
    load_sum(0);
    tile_done = 1'b1;
    tick;
    tile_done = 1'b0;
    drain_beats("b2b_a", 0, 0, 14);
    load_sum(1);
    tile_done = 1'b1;
    #1;
    check("b2b_idx15", 64'(out_idx),    64'(15));
    check("b2b_d15",   64'(out_data),   64'(pat(0, 15)));
    check("b2b_dr",    64'(done_ready), 64'(1));
    check("b2b_clr",   64'(acc_clear),  64'(1));
    tick;
    tile_done = 1'b0;
    acc_sum   = '0;
    check("b2b_tiles_a", 64'(tiles_drained), 64'(3));
    drain_beats("b2b_b", 1, 0, 15);
    #1;
    check("b2b_idle",    64'(out_valid),     64'(0));
    check("b2b_tiles_b", 64'(tiles_drained), 64'(4));

    // Overrun mid-drain at idx 5
    tick;
    load_sum(0);
    tile_done = 1'b1;
    tick;
    tile_done = 1'b0;
    drain_beats("ovr_pre", 0, 0, 4);
    load_sum(3);
    tile_done = 1'b1;
    #1;
    check("ovr_clr", 64'(acc_clear),  64'(0));
    check("ovr_dr",  64'(done_ready), 64'(0));
    check("ovr_idx", 64'(out_idx),    64'(5));
    tick;
    tile_done = 1'b0;
    check("ovr_flag", 64'(overrun), 64'(1));
    drain_beats("ovr_post", 0, 6, 15);
    #1;
    check("ovr_idle",   64'(out_valid),     64'(0));
    check("ovr_sticky", 64'(overrun),       64'(1));
    check("ovr_tiles",  64'(tiles_drained), 64'(5));

    // Reset mid-drain at idx 8
    tick;
    load_sum(2);
    tile_done = 1'b1;
    tick;
    tile_done = 1'b0;
    drain_beats("rmd_pre", 2, 0, 7);
    nRST = 1'b0;
    tick;
    nRST = 1'b1;
    #1;
    check("rmd_valid",   64'(out_valid),     64'(0));
    check("rmd_overrun", 64'(overrun),       64'(0));
    check("rmd_tiles",   64'(tiles_drained), 64'(0));
    check("rmd_dr",      64'(done_ready),    64'(1));
    load_sum(0);
    tile_done = 1'b1;
    #1;
    check("rmd_clr", 64'(acc_clear), 64'(1));
    tick;
    tile_done = 1'b0;
    drain_beats("rmd_post", 0, 0, 15);
    #1;
    check("rmd_tiles2", 64'(tiles_drained), 64'(1));

    // Counter wrap: preset to 65535, then one more tile
    force dut.tiles_drained = 16'hFFFF;
    #1;
    release dut.tiles_drained;
    tick;
    load_sum(1);
    tile_done = 1'b1;
    tick;
    tile_done = 1'b0;
    drain_beats("wrap", 1, 0, 15);
    #1;
    check("wrap_tiles", 64'(tiles_drained), 64'(0));
    check("wrap_idle",  64'(out_valid),     64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
